// File: rtl/uart_pkg.sv
// Shared UART definitions: the receive FSM state encoding and a baud-rate helper.
// The future transmitter imports this package as well.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Clock cycles per bit for a given system clock and baud rate.
  // The result is truncated, e.g. 100 MHz / 9600 Bd gives 10416.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Front end of the UART receiver. It contains the 2-FF synchroniser for the
// asynchronous rx pin, the falling-edge detector that starts a frame, and the
// 3-sample majority vote taken at counts H-1, H and H+1 (H = CLKS_PER_BIT/2).
// The vote output is meaningful only while cnt == H+1.
module uart_bit_sampler #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx,
  input  logic [$clog2(CLKS_PER_BIT)-1:0] cnt,
  output logic                            rx_s,
  output logic                            fall,
  output logic                            vote
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] SMP0_AT = CW'(H - 1);
  localparam logic [CW-1:0] SMP1_AT = CW'(H);

  logic rx_m;
  logic rx_d;
  logic smp0;
  logic smp1;

  // Synchronise rx and keep one delayed copy for edge detection; idle-high reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // A held-low line produces only one edge, so a break cannot retrigger a frame.
  assign fall = rx_d & ~rx_s;

  // Capture the first two vote samples; the third is the live rx_s at H+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp0 <= 1'b0;
      smp1 <= 1'b0;
    end else begin
      if (cnt == SMP0_AT) smp0 <= rx_s;
      if (cnt == SMP1_AT) smp1 <= rx_s;
    end
  end

  assign vote = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (5..9 data bits LSB first, 1..2 stop bits).
// Optional parity is enabled by defining the macro UART_RX_PARITY_EN.
// Handshake: rx_data/rx_valid form a one-entry holding register; a word moves
// to the consumer in any cycle where rx_valid && rx_ready, rx_ready is ignored
// while rx_valid=0, and rx_data is frozen while rx_valid=1 without a transfer.
// A frame completing while the register is full and not being drained is
// dropped and reported with a one-cycle overrun pulse.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] VOTE_AT   = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  // FSM state is kept as a named register so checkers can bind to it directly.
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 stop_bad;
  logic [DATA_BITS-1:0] data_sr;
  logic                 rx_sync_unused;
  logic                 fall;
  logic                 vote;
  logic                 at_vote;
  logic                 at_end;

  uart_bit_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .cnt  (cnt),
    .rx_s (rx_sync_unused),
    .fall (fall),
    .vote (vote)
  );

  assign at_vote = (cnt == VOTE_AT);
  assign at_end  = (cnt == LAST_CNT);
  assign busy    = (state != S_IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign parity_err        = 1'b0;
`endif

  // Frame FSM with bit counters, shift register, holding register and flag pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      stop_bad  <= 1'b0;
      data_sr   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // A transfer empties the register; a coinciding load below overrides this.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (fall) state <= S_START;
        end

        S_START: begin
          cnt <= at_end ? '0 : cnt + CW'(1);
          if (at_vote && vote) begin
            // Line went back high before mid-bit: noise, not a start bit.
            state <= S_IDLE;
            cnt   <= '0;
          end else if (at_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
        end

        S_DATA: begin
          cnt <= at_end ? '0 : cnt + CW'(1);
          if (at_vote) data_sr <= {vote, data_sr[DATA_BITS-1:1]};
          if (at_end) begin
            if (bit_idx == LAST_BIT) begin
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
              state    <= S_PARITY;
`else
              state    <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          cnt <= at_end ? '0 : cnt + CW'(1);
          if (at_vote) par_bad <= vote ^ (^data_sr) ^ (PARITY_ODD != 0);
          if (at_end) state <= S_STOP;
        end
`endif

        S_STOP: begin
          cnt <= at_end ? '0 : cnt + CW'(1);
          if (at_vote && (stop_idx == LAST_STOP)) begin
            // Leave at the last stop vote so a following start edge is not missed.
            state     <= S_IDLE;
            cnt       <= '0;
            frame_err <= stop_bad | ~vote;
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bad;
`endif
            if (!rx_valid || rx_ready) begin
              rx_data  <= data_sr;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            if (at_vote) stop_bad <= stop_bad | ~vote;
            if (at_end) stop_idx <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param at CLKS_PER_BIT=16, 8 data bits, 1 stop bit.
// Expected words are queued as frames are sent and matched against words the
// consumer side actually accepts; flag pulses are counted per test.
module tb_uart_rx_param;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          busy;

  uart_rx_param #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .STOP_BITS   (1),
    .PARITY_ODD  (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] got_q[$];

  int n_ferr  = 0;
  int n_perr  = 0;
  int n_ovr   = 0;
  int n_valid = 0;

  // Monitor: record accepted words and count flag pulses, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err)  n_ferr++;
    if (parity_err) n_perr++;
    if (overrun)    n_ovr++;
    if (rx_valid)   n_valid++;
  end

  typedef struct {
    logic [DB-1:0] data;
    logic          stop_val;
    logic [DB-1:0] exp_data;
    int            exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_val);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_val);
  endtask

  // Scoreboard: every accepted word must match the next expected word, in order.
  task automatic expect_words(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [DB-1:0] g;
      logic [DB-1:0] e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({name, "_data"}, g, e);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  int f0, o0, p0, v0;
  int busy_hits;

  initial begin
    vecs[0] = '{data: 8'hA5, stop_val: 1'b1, exp_data: 8'hA5, exp_ferr: 0};
    vecs[1] = '{data: 8'h00, stop_val: 1'b1, exp_data: 8'h00, exp_ferr: 0};
    vecs[2] = '{data: 8'hFF, stop_val: 1'b1, exp_data: 8'hFF, exp_ferr: 0};
    vecs[3] = '{data: 8'h5A, stop_val: 1'b1, exp_data: 8'h5A, exp_ferr: 0};
    vecs[4] = '{data: 8'h80, stop_val: 1'b1, exp_data: 8'h80, exp_ferr: 0};
    vecs[5] = '{data: 8'h3F, stop_val: 1'b0, exp_data: 8'h3F, exp_ferr: 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_parity_err", parity_err, 0);
    rst_n = 1'b1;
    idle_bits(2);
    rx_ready = 1'b1;

    // Table-driven frames with the consumer always ready
    for (int i = 0; i < 6; i++) begin
      f0 = n_ferr; o0 = n_ovr; p0 = n_perr; v0 = n_valid;
      exp_q.push_back(vecs[i].exp_data);
      send_frame(vecs[i].data, vecs[i].stop_val);
      idle_bits(2);
      expect_words($sformatf("v%0d", i));
      chk($sformatf("v%0d_frame_err", i), n_ferr - f0, vecs[i].exp_ferr);
      chk($sformatf("v%0d_overrun", i), n_ovr - o0, 0);
      chk($sformatf("v%0d_parity_err", i), n_perr - p0, 0);
      chk($sformatf("v%0d_valid_cycles", i), n_valid - v0, 1);
    end

    // Overrun: two frames with the consumer stalled
    rx_ready = 1'b0;
    f0 = n_ferr; o0 = n_ovr;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle_bits(1);
    chk("ovr_first_valid", rx_valid, 1);
    chk("ovr_first_data", rx_data, 8'h3C);
    send_frame(8'hC3, 1'b1);
    idle_bits(1);
    chk("ovr_pulse", n_ovr - o0, 1);
    chk("ovr_data_kept", rx_data, 8'h3C);
    chk("ovr_valid_kept", rx_valid, 1);
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    expect_words("ovr");
    chk("ovr_valid_drained", rx_valid, 0);
    chk("ovr_no_ferr", n_ferr - f0, 0);

    // False start: 4-cycle low pulse
    f0 = n_ferr; o0 = n_ovr; p0 = n_perr; v0 = n_valid;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    chk("fs_busy_in_start", busy, 1);
    idle_bits(2);
    chk("fs_busy_idle", busy, 0);
    chk("fs_valid", rx_valid, 0);
    chk("fs_valid_cycles", n_valid - v0, 0);
    chk("fs_flags", (n_ferr - f0) + (n_ovr - o0) + (n_perr - p0), 0);
    expect_words("fs");

    // Framing error followed by a held-low line
    f0 = n_ferr;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0);
    busy_hits = 0;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      if (busy) busy_hits++;
    end
    chk("brk_no_retrigger", busy_hits, 0);
    idle_bits(2);
    chk("brk_busy_after_release", busy, 0);
    expect_words("brk");
    chk("brk_frame_err", n_ferr - f0, 1);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has odd weight, so parity bit 0 is wrong and 1 is right
    for (int k = 0; k < 2; k++) begin
      logic [7:0] pd;
      logic pb;
      pd = 8'h07;
      pb = (k == 1);
      p0 = n_perr;
      exp_q.push_back(pd);
      send_bit(1'b0);
      for (int i = 0; i < DB; i++) send_bit(pd[i]);
      send_bit(pb);
      send_bit(1'b1);
      idle_bits(2);
      expect_words($sformatf("par%0d", k));
      chk($sformatf("par%0d_parity_err", k), n_perr - p0, (^pd) ^ pb);
    end
`endif

    // Reset during data bit 3 with a word held
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle_bits(1);
    chk("mid_held_valid", rx_valid, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rx_data", rx_data, 0);
    chk("mid_rx_valid", rx_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_frame_err", frame_err, 0);
    chk("mid_overrun", overrun, 0);
    chk("mid_parity_err", parity_err, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    idle_bits(2);
    rx_ready = 1'b1;
    f0 = n_ferr; o0 = n_ovr;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle_bits(2);
    expect_words("post_rst");
    chk("post_rst_flags", (n_ferr - f0) + (n_ovr - o0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends with a summary.
  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout: got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
